// File: rtl/mips_dmem_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus an MMIO page
// holding a TX FIFO, a free-running cycle counter and a one-shot down-timer.
module mips_dmem_responder #(
  parameter int unsigned DATA_MEM_WIDTH = 32,
  parameter int unsigned RAM_DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      memwrite,
  input  logic [DATA_MEM_WIDTH-1:0] memaddr,
  input  logic [DATA_MEM_WIDTH-1:0] writedata,
  output logic [DATA_MEM_WIDTH-1:0] readdata,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  output logic                      irq
);

  localparam int unsigned DW  = DATA_MEM_WIDTH;
  localparam int unsigned RAW = $clog2(RAM_DEPTH);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [DW-5:0] MMIO_PAGE = (DW-4)'(28'hFFFF000);

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;
  localparam logic [1:0] REG_TIMER  = 2'd3;

  logic [DW-1:0] ram_q [RAM_DEPTH];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] cycle_q, cycle_d, timer_q, timer_d;
  logic          ovf_q, ovf_d, exp_q, exp_d;

  logic          sel_ram, sel_mmio;
  logic [1:0]    reg_sel;
  logic [RAW-1:0] ram_idx;
  logic          we_tx, we_status, we_cycle, we_timer;
  logic          fifo_empty, fifo_full, pop, push_ok;
  logic          unused_addr_lsbs;

  // Address decode; byte offset bits are don't-care for word accesses
  assign sel_ram          = ~memaddr[DW-1];
  assign sel_mmio         = (memaddr[DW-1:4] == MMIO_PAGE);
  assign reg_sel          = memaddr[3:2];
  assign ram_idx          = memaddr[RAW+1:2];
  assign unused_addr_lsbs = ^memaddr[1:0];

  assign we_tx     = memwrite && sel_mmio && (reg_sel == REG_TX);
  assign we_status = memwrite && sel_mmio && (reg_sel == REG_STATUS);
  assign we_cycle  = memwrite && sel_mmio && (reg_sel == REG_CYCLE);
  assign we_timer  = memwrite && sel_mmio && (reg_sel == REG_TIMER);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok    = we_tx && (!fifo_full || pop);

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign irq      = exp_q;

  // Combinational load path
  always_comb begin
    readdata = '0;
    if (sel_ram) begin
      readdata = ram_q[ram_idx];
    end else if (sel_mmio) begin
      case (reg_sel)
        REG_STATUS: readdata = DW'({exp_q, ovf_q, fifo_full, fifo_empty});
        REG_CYCLE:  readdata = cycle_q;
        REG_TIMER:  readdata = timer_q;
        default:    readdata = '0;
      endcase
    end
  end

  // Next-state for FIFO bookkeeping, counters and sticky flags
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cycle_d  = cycle_q + DW'(1);
    timer_d  = timer_q;
    ovf_d    = ovf_q;
    exp_d    = exp_q;

    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    if (we_cycle) cycle_d = writedata;

    if (we_timer)              timer_d = writedata;
    else if (timer_q != '0)    timer_d = timer_q - DW'(1);

    // Set beats a simultaneous write-1-to-clear
    if (we_status && writedata[2]) ovf_d = 1'b0;
    if (we_status && writedata[3]) exp_d = 1'b0;
    if (we_tx && !push_ok)         ovf_d = 1'b1;
    if (!we_timer && (timer_q == DW'(1))) exp_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= '0;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
      exp_q    <= exp_d;
    end
  end

  // Storage arrays are not reset; RAM survives reset, FIFO slots are masked by count
  always_ff @(posedge clk) begin
    if (memwrite && sel_ram) ram_q[ram_idx] <= writedata;
    if (push_ok)             fifo_q[wr_ptr_q] <= writedata[7:0];
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized bench for mips_dmem_responder against a queue-based reference model,
// with directed sequences pinning literal values.
module tb_mips_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  localparam logic [31:0] A_TX     = 32'hFFFF0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF0008;
  localparam logic [31:0] A_TIMER  = 32'hFFFF000C;

  mips_dmem_responder #(.DATA_MEM_WIDTH(32), .RAM_DEPTH(256), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .memaddr(memaddr),
    .writedata(writedata), .readdata(readdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [31:0] mcyc, mtmr;
  bit          movf, mexp;
  logic [31:0] mram [256];
  bit          mram_v [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    mcyc = '0;
    mtmr = '0;
    movf = 1'b0;
    mexp = 1'b0;
  endtask

  task automatic exp_read(input logic [31:0] a, output bit ok, output logic [31:0] v);
    logic [7:0] idx;
    ok = 1'b1;
    v  = '0;
    idx = a[9:2];
    if (!a[31]) begin
      ok = mram_v[idx];
      v  = mram[idx];
    end else if (a[31:4] == 28'hFFFF000) begin
      case (a[3:2])
        2'd1: v = {28'b0, mexp, movf, (mq.size() == 4), (mq.size() == 0)};
        2'd2: v = mcyc;
        2'd3: v = mtmr;
        default: v = '0;
      endcase
    end
  endtask

  // Compare every output against the model at the mid-cycle sample point
  task automatic check_model();
    bit          ok;
    logic [31:0] v;
    chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
    chk("tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk("irq", 32'(irq), 32'(mexp));
    exp_read(memaddr, ok, v);
    if (ok) chk("readdata", readdata, v);
  endtask

  // Apply one clock edge's worth of the specification's rules to the model
  task automatic model_step();
    bit         mmio, wtx, wst, wcy, wtm, pop, acc, exp_set;
    logic [7:0] dummy;
    logic [7:0] idx;
    mmio = (memaddr[31:4] == 28'hFFFF000);
    wtx  = memwrite && mmio && (memaddr[3:2] == 2'd0);
    wst  = memwrite && mmio && (memaddr[3:2] == 2'd1);
    wcy  = memwrite && mmio && (memaddr[3:2] == 2'd2);
    wtm  = memwrite && mmio && (memaddr[3:2] == 2'd3);
    pop  = (mq.size() != 0) && tx_ready;
    acc  = wtx && ((mq.size() < 4) || pop);
    idx  = memaddr[9:2];
    if (memwrite && !memaddr[31]) begin
      mram[idx]   = writedata;
      mram_v[idx] = 1'b1;
    end
    if (pop) dummy = mq.pop_front();
    if (acc) mq.push_back(writedata[7:0]);
    mcyc = wcy ? writedata : mcyc + 32'd1;
    exp_set = 1'b0;
    if (wtm) mtmr = writedata;
    else if (mtmr != 0) begin
      exp_set = (mtmr == 32'd1);
      mtmr = mtmr - 32'd1;
    end
    movf = (wtx && !acc) || (movf && !(wst && writedata[2]));
    mexp = exp_set || (mexp && !(wst && writedata[3]));
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    memwrite  = we;
    memaddr   = a;
    writedata = d;
    tx_ready  = rdy;
    #4;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    drive(we, a, d, rdy);
    tick();
  endtask

  initial begin
    logic [31:0] a, d;
    int          sel;
    for (int i = 0; i < 256; i++) mram_v[i] = 1'b0;
    rst_n = 1'b0; memwrite = 1'b0; memaddr = A_CYCLE; writedata = '0; tx_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_cycle", readdata, 32'h0);
    #8 rst_n = 1'b1;

    drive(0, A_CYCLE, 0, 0); chk("cycle_first", readdata, 32'h0); tick();

    // RAM store/load and aliasing
    cyc(1, 32'h00000010, 32'hDEADBEEF, 0);
    drive(0, 32'h00000010, 0, 0); chk("ram_load", readdata, 32'hDEADBEEF); tick();
    drive(0, 32'h00000410, 0, 0); chk("ram_alias", readdata, 32'hDEADBEEF); tick();

    // FIFO fill then drain at one byte per cycle
    cyc(1, A_TX, 32'h41, 0); cyc(1, A_TX, 32'h42, 0); cyc(1, A_TX, 32'h43, 0);
    drive(0, A_STATUS, 0, 0); chk("status_3", readdata, 32'h0); tick();
    drive(0, A_STATUS, 0, 1); chk("drain_0", 32'(tx_data), 32'h41); tick();
    drive(0, A_STATUS, 0, 1); chk("drain_1", 32'(tx_data), 32'h42); tick();
    drive(0, A_STATUS, 0, 1); chk("drain_2", 32'(tx_data), 32'h43); tick();
    drive(0, A_STATUS, 0, 0); chk("drain_valid", 32'(tx_valid), 32'h0);
    chk("status_empty", readdata, 32'h1); tick();

    // Overflow, W1C and push-while-full-with-pop
    for (int i = 0; i < 5; i++) cyc(1, A_TX, 32'h51 + 32'(i), 0);
    drive(0, A_STATUS, 0, 0); chk("status_ovf", readdata, 32'h6); tick();
    cyc(1, A_STATUS, 32'h4, 0);
    drive(0, A_STATUS, 0, 0); chk("status_clr", readdata, 32'h2); tick();
    drive(1, A_TX, 32'h56, 1); chk("full_pop_head", 32'(tx_data), 32'h51); tick();
    drive(0, A_STATUS, 0, 0); chk("status_fullpop", readdata, 32'h2);
    chk("head_after", 32'(tx_data), 32'h52); tick();
    for (int i = 0; i < 4; i++) cyc(0, A_STATUS, 0, 1);
    drive(0, A_STATUS, 0, 0); chk("fifo_last_empty", readdata, 32'h1); tick();

    // Timer expiry with a colliding clear
    cyc(1, A_TIMER, 32'd3, 0);
    drive(0, A_TIMER, 0, 0); chk("timer_3", readdata, 32'd3); tick();
    drive(0, A_TIMER, 0, 0); chk("timer_2", readdata, 32'd2); tick();
    drive(1, A_STATUS, 32'h8, 0); chk("irq_pre", 32'(irq), 32'h0); tick();
    drive(0, A_TIMER, 0, 0); chk("timer_0", readdata, 32'd0); chk("irq_set", 32'(irq), 32'h1); tick();
    drive(0, A_TIMER, 0, 0); chk("timer_hold", readdata, 32'd0); chk("irq_hold", 32'(irq), 32'h1); tick();
    cyc(1, A_STATUS, 32'h8, 0);
    drive(0, A_STATUS, 0, 0); chk("irq_clr", 32'(irq), 32'h0); chk("status_exp_clr", readdata, 32'h1); tick();

    // Cycle counter wrap
    cyc(1, A_CYCLE, 32'hFFFFFFFE, 0);
    drive(0, A_CYCLE, 0, 0); chk("cyc_fe", readdata, 32'hFFFFFFFE); tick();
    drive(0, A_CYCLE, 0, 0); chk("cyc_ff", readdata, 32'hFFFFFFFF); tick();
    drive(0, A_CYCLE, 0, 0); chk("cyc_wrap", readdata, 32'h0); tick();

    // Randomized traffic across RAM, MMIO and unmapped space (RAM word 8 kept aside)
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel < 4) begin
        a = {1'b0, 31'($urandom)};
        if (a[9:2] == 8'd8) a[2] = 1'b1;
      end else if (sel < 9) begin
        a = 32'hFFFF0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        if (a[3:2] == 2'd3) d = 32'($urandom_range(0, 12));
      end else begin
        a = 32'hC0000000 | ($urandom & 32'h0FFFFFFF);
      end
      cyc(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 2) == 0));
    end

    // Reset mid-run: non-empty FIFO, running timer, EXP set
    cyc(1, 32'h00000020, 32'hCAFEF00D, 0);
    cyc(1, A_STATUS, 32'hC, 0);
    for (int i = 0; i < 4; i++) cyc(0, A_STATUS, 0, 1);
    cyc(1, A_TX, 32'h61, 0);
    cyc(1, A_TX, 32'h62, 0);
    cyc(1, A_TIMER, 32'd1, 0);
    cyc(0, A_STATUS, 0, 0);
    cyc(1, A_TIMER, 32'd9, 0);
    drive(0, A_TIMER, 0, 0);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk("pre_rst_valid", 32'(tx_valid), 32'h1);
    chk("pre_rst_timer", readdata, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_data", 32'(tx_data), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_timer", readdata, 32'h0);
    model_reset();
    rst_n = 1'b1;
    tick();
    drive(0, 32'h00000020, 0, 0); chk("ram_kept", readdata, 32'hCAFEF00D); tick();
    drive(0, A_CYCLE, 0, 0); chk("cyc_after_rst", readdata, 32'd2); tick();
    drive(0, A_STATUS, 0, 0); chk("status_after_rst", readdata, 32'h1); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
